// File: rtl/stream_flush_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stream_flush_pkg
//  Description : Shared definitions for stream_flush_source. Holds the
//                sequencer state encoding and the helper that sizes the
//                flush-duration counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package stream_flush_pkg;

    // Sequencer states: normal streaming, flush asserted, one-cycle ack.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_ACK   = 2'd2
    } state_e;

    // Width of the flush-duration counter. The extra bit keeps the
    // FlushCycles-1 load value representable for every legal FlushCycles.
    function automatic int flush_cnt_width(input int flush_cycles);
        return $clog2(flush_cycles) + 1;
    endfunction

endpackage : stream_flush_pkg
`default_nettype wire

// File: rtl/stream_flush_source.sv
`default_nettype none
// ============================================================================
//  Module      : stream_flush_source
//  Description : Upstream driver for a chain of flushable spill stages.
//                Forwards valid/ready beats through one registered output
//                stage and, on request, sequences a flush: flush_o is held
//                for FlushCycles cycles, then flush_ack_o pulses once.
//                flush_o and valid_o are never high together.
//  Ports       : clk, rst          - clock, async active-high reset
//                in_valid_i/in_ready_o/in_data_i - upstream beat interface
//                flush_req_i       - flush request (level, sampled in RUN)
//                flush_ack_o       - one-cycle pulse at end of flush
//                valid_o/ready_i/data_o - downstream beat interface
//                flush_o           - downstream flush (registered)
//                beat_cnt_o        - beats delivered since last flush (sat.)
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_flush_source
    import stream_flush_pkg::*;
#(
    parameter type T           = logic,
    parameter int  FlushCycles = 2,
    parameter int  CntWidth    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  T                    in_data_i,
    input  logic                flush_req_i,
    output logic                flush_ack_o,
    output logic                valid_o,
    input  logic                ready_i,
    output T                    data_o,
    output logic                flush_o,
    output logic [CntWidth-1:0] beat_cnt_o
);

    localparam int                  FCW        = flush_cnt_width(FlushCycles);
    localparam logic [FCW-1:0]      FLUSH_LOAD = FCW'(FlushCycles - 1);
    localparam logic [CntWidth-1:0] CNT_MAX    = '1;

    state_e                state;
    logic                  out_valid_q;
    T                      out_data_q;
    logic                  flush_q;
    logic                  ack_q;
    logic [CntWidth-1:0]   beat_cnt_q;
    logic [FCW-1:0]        flush_cnt_q;

    logic                  in_hs;
    logic                  out_hs;

    // A pending flush request closes the input immediately so that no new
    // beat is captured in the cycle that decides to flush.
    assign in_ready_o = (state == ST_RUN) && !flush_req_i
                        && (!out_valid_q || ready_i);
    assign in_hs      = in_valid_i && in_ready_o;
    assign out_hs     = (state == ST_RUN) && out_valid_q && ready_i;

    assign valid_o     = out_valid_q;
    assign data_o      = out_data_q;
    assign flush_o     = flush_q;
    assign flush_ack_o = ack_q;
    assign beat_cnt_o  = beat_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_RUN;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            flush_q     <= 1'b0;
            ack_q       <= 1'b0;
            beat_cnt_q  <= '0;
            flush_cnt_q <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (flush_req_i) begin
                        // Any undelivered beat is dropped; a downstream
                        // handshake this cycle still completes, but the
                        // count is cleared on entry to FLUSH anyway.
                        state       <= ST_FLUSH;
                        out_valid_q <= 1'b0;
                        flush_q     <= 1'b1;
                        beat_cnt_q  <= '0;
                        flush_cnt_q <= FLUSH_LOAD;
                    end else begin
                        if (in_hs) begin
                            out_valid_q <= 1'b1;
                            out_data_q  <= in_data_i;
                        end else if (out_hs) begin
                            out_valid_q <= 1'b0;
                        end
                        if (out_hs && (beat_cnt_q != CNT_MAX)) begin
                            beat_cnt_q <= beat_cnt_q + 1'b1;
                        end
                    end
                end

                ST_FLUSH: begin
                    // Counter starts at FlushCycles-1, so flush_o spans
                    // exactly FlushCycles cycles before the ack cycle.
                    if (flush_cnt_q == '0) begin
                        state   <= ST_ACK;
                        flush_q <= 1'b0;
                        ack_q   <= 1'b1;
                    end else begin
                        flush_cnt_q <= flush_cnt_q - 1'b1;
                    end
                end

                ST_ACK: begin
                    ack_q <= 1'b0;
                    state <= ST_RUN;
                end

                default: begin
                    state       <= ST_RUN;
                    out_valid_q <= 1'b0;
                    flush_q     <= 1'b0;
                    ack_q       <= 1'b0;
                end
            endcase
        end
    end

endmodule : stream_flush_source
`default_nettype wire

// File: tb/tb_stream_flush_source.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_flush_source
//  Description : Directed self-checking bench for stream_flush_source.
//                Two instances share stimulus: dut_a (FlushCycles=3,
//                CntWidth=16) and dut_b (FlushCycles=2, CntWidth=3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_flush_source;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       flush_req;
    logic       ready;

    logic        in_ready_a, ack_a, valid_a, flush_a;
    logic [7:0]  data_a;
    logic [15:0] cnt_a;
    logic        in_ready_b, ack_b, valid_b, flush_b;
    logic [7:0]  data_b;
    logic [2:0]  cnt_b;

    int total;
    int bad;

    logic [7:0] fl_exp;
    logic [7:0] ack_exp;

    stream_flush_source #(
        .T           (logic [7:0]),
        .FlushCycles (3),
        .CntWidth    (16)
    ) dut_a (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready_a),
        .in_data_i   (in_data),
        .flush_req_i (flush_req),
        .flush_ack_o (ack_a),
        .valid_o     (valid_a),
        .ready_i     (ready),
        .data_o      (data_a),
        .flush_o     (flush_a),
        .beat_cnt_o  (cnt_a)
    );

    stream_flush_source #(
        .T           (logic [7:0]),
        .FlushCycles (2),
        .CntWidth    (3)
    ) dut_b (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready_b),
        .in_data_i   (in_data),
        .flush_req_i (flush_req),
        .flush_ack_o (ack_b),
        .valid_o     (valid_b),
        .ready_i     (ready),
        .data_o      (data_b),
        .flush_o     (flush_b),
        .beat_cnt_o  (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, settle, and check the flush/valid exclusivity.
    task automatic tick();
        @(posedge clk);
        #2;
        chk("inv_a", 32'(flush_a & valid_a), 32'd0);
        chk("inv_b", 32'(flush_b & valid_b), 32'd0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        flush_req = 1'b0;
        ready     = 1'b1;
        fl_exp    = 8'b0011_0011;
        ack_exp   = 8'b0100_0100;

        // ---------------- reset state ----------------
        tick();
        tick();
        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_flush", 32'(flush_a), 32'd0);
        chk("rst_ack",   32'(ack_a),   32'd0);
        chk("rst_cnt_a", 32'(cnt_a),   32'd0);
        chk("rst_cnt_b", 32'(cnt_b),   32'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready_a), 32'd1);

        // ---------------- 1: streaming ----------------
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h10 + i);
            tick();
            chk("t1_valid", 32'(valid_a), 32'd1);
            chk("t1_data",  32'(data_a),  32'(8'h10 + i));
        end
        in_valid = 1'b0;
        tick();
        chk("t1_valid_end", 32'(valid_a), 32'd0);
        chk("t1_cnt_a",     32'(cnt_a),   32'd8);
        chk("t1_cnt_b_sat", 32'(cnt_b),   32'd7);

        // ---------------- 2: backpressure ----------------
        ready    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hAB;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t2_in_ready", 32'(in_ready_a), 32'd0);
            chk("t2_valid",    32'(valid_a),    32'd1);
            chk("t2_data",     32'(data_a),     32'hAB);
            tick();
        end
        ready = 1'b1;
        tick();
        chk("t2_valid_done", 32'(valid_a), 32'd0);
        chk("t2_cnt_a",      32'(cnt_a),   32'd9);

        // ---------------- 3: flush with pending beat ----------------
        ready    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hCD;
        tick();
        in_valid = 1'b0;
        tick();
        chk("t3_held_valid", 32'(valid_a), 32'd1);
        chk("t3_held_data",  32'(data_a),  32'hCD);
        flush_req = 1'b1;
        #1;
        chk("t3_req_in_ready", 32'(in_ready_a), 32'd0);
        tick();                                   // flush cycle 1
        flush_req = 1'b0;
        ready     = 1'b1;
        chk("t3_f1_flush", 32'(flush_a), 32'd1);
        chk("t3_f1_valid", 32'(valid_a), 32'd0);
        chk("t3_f1_cnt",   32'(cnt_a),   32'd0);
        chk("t3_f1_ack",   32'(ack_a),   32'd0);
        tick();                                   // flush cycle 2
        chk("t3_f2_flush",   32'(flush_a), 32'd1);
        chk("t3_f2_valid",   32'(valid_a), 32'd0);
        chk("t3_f2_flush_b", 32'(flush_b), 32'd1);
        tick();                                   // flush cycle 3
        chk("t3_f3_flush", 32'(flush_a), 32'd1);
        chk("t3_f3_ack",   32'(ack_a),   32'd0);
        chk("t3_ack_b",    32'(ack_b),   32'd1);
        tick();                                   // ack cycle
        chk("t3_ack_flush", 32'(flush_a), 32'd0);
        chk("t3_ack",       32'(ack_a),   32'd1);
        chk("t3_ack_valid", 32'(valid_a), 32'd0);
        tick();                                   // back in RUN
        chk("t3_run_ack",      32'(ack_a),      32'd0);
        chk("t3_run_valid",    32'(valid_a),    32'd0);
        chk("t3_run_cnt",      32'(cnt_a),      32'd0);
        chk("t3_run_in_ready", 32'(in_ready_a), 32'd1);

        // ---------------- 5: saturation ----------------
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("t5_cnt_b", 32'(cnt_b), 32'd7);
        chk("t5_cnt_a", 32'(cnt_a), 32'd10);

        // ---------------- 4: overlapping request (dut_b) ----------------
        flush_req = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 6) flush_req = 1'b0;
            chk("t4_flush_b", 32'(flush_b), 32'(fl_exp[k-1]));
            chk("t4_ack_b",   32'(ack_b),   32'(ack_exp[k-1]));
            chk("t4_valid_b", 32'(valid_b), 32'd0);
            if (k == 4) begin
                #1;
                chk("t4_rerun_in_ready", 32'(in_ready_b), 32'd0);
            end
        end
        tick();
        tick();
        tick();
        chk("t4_cnt_b", 32'(cnt_b), 32'd0);
        chk("t4_cnt_a", 32'(cnt_a), 32'd0);

        // ---------------- 6: reset mid-flush ----------------
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        chk("t6_f1_flush", 32'(flush_a), 32'd1);
        tick();
        chk("t6_f2_flush", 32'(flush_a), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_async_flush", 32'(flush_a), 32'd0);
        chk("t6_async_valid", 32'(valid_a), 32'd0);
        chk("t6_async_ack",   32'(ack_a),   32'd0);
        chk("t6_async_cnt",   32'(cnt_a),   32'd0);
        tick();
        chk("t6_rst_ack1", 32'(ack_a), 32'd0);
        tick();
        chk("t6_rst_ack2", 32'(ack_a), 32'd0);
        rst      = 1'b0;
        ready    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        tick();
        chk("t6_beat_valid", 32'(valid_a), 32'd1);
        chk("t6_beat_data",  32'(data_a),  32'h55);
        chk("t6_no_ack",     32'(ack_a),   32'd0);
        in_valid = 1'b0;
        tick();
        chk("t6_valid_end", 32'(valid_a), 32'd0);
        chk("t6_cnt_a",     32'(cnt_a),   32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_stream_flush_source
`default_nettype wire
